// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Bit positions of each segment within the active-low seg bus.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW,
    COMMIT
  } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 are dark.
module bcd_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  logic [6:0] w_on;

  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    w_on = '0;
    if (i_bcd <= 4'd9) begin
      w_on[SEG_A] = !(i_bcd inside {4'd1, 4'd4});
      w_on[SEG_B] = !(i_bcd inside {4'd5, 4'd6});
      w_on[SEG_C] = (i_bcd != 4'd2);
      w_on[SEG_D] = !(i_bcd inside {4'd1, 4'd4, 4'd7});
      w_on[SEG_E] = (i_bcd inside {4'd0, 4'd2, 4'd6, 4'd8});
      w_on[SEG_F] = !(i_bcd inside {4'd1, 4'd2, 4'd3, 4'd7});
      w_on[SEG_G] = !(i_bcd inside {4'd0, 4'd1, 4'd7});
    end
  end

  assign o_seg = ~w_on;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode display scanner with a tear-free shadow/active digit bank.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 12000,
  parameter int BLANK_CYC  = 16,
  parameter int AW         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lz_suppress,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_n,
  output logic                  frame_done
);

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICK_DIV - 1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_DIGITS - 1);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [AW-1:0]         r_idx, w_idx_nxt;
  logic [3:0]            r_shadow [NUM_DIGITS];
  logic [3:0]            r_active [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic                  w_zero_run;
  logic [6:0]            w_dec, w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_dig_nxt;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
      BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = COMMIT;
          end else begin
            w_state_nxt = BLANK;
            w_idx_nxt   = r_idx + AW'(1);
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      COMMIT: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
    if (!en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run    = w_zero_run && (r_active[i] == 4'd0);
      w_lz_blank[i] = lz_suppress && (i != 0) && w_zero_run;
    end
  end

  bcd_to_7seg u_dec (
    .i_bcd (r_active[w_idx_nxt]),
    .o_seg (w_dec)
  );

  // NOTE: outputs are decoded from the next state so the registered pins line up with the state register.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_dig_nxt = '1;
    if (w_state_nxt == SHOW) begin
      w_dig_nxt[w_idx_nxt] = 1'b0;
      if (!w_lz_blank[w_idx_nxt]) w_seg_nxt = w_dec;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; both banks are reset
  // because blank (4'hF) is the defined power-up display content.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      wr_ready   <= 1'b0;
      frame_done <= 1'b0;
      seg        <= SEG_BLANK;
      dig_n      <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= 4'hF;
        r_active[i] <= 4'hF;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      wr_ready   <= (w_state_nxt != COMMIT);
      frame_done <= (w_state_nxt == COMMIT);
      seg        <= w_seg_nxt;
      dig_n      <= w_dig_nxt;
      if (wr_valid && wr_ready && (int'(wr_addr) < NUM_DIGITS)) begin
        r_shadow[wr_addr] <= wr_data;
      end
      // Commit at the end of the COMMIT cycle so a write landing on the edge into COMMIT is included.
      if (r_state == COMMIT) begin
        for (int i = 0; i < NUM_DIGITS; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed-vector bench for seg_scan_ctrl with 4 digits, 4-cycle show, 2-cycle blank.
module tb_seg_scan_ctrl;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [3:0] DARK = 4'b1111;

  logic       clk = 1'b0;
  logic       rst, en, lz_suppress, wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [6:0] seg;
  logic [3:0] dig_n;
  logic       frame_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] dig_tab = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .TICK_DIV   (4),
    .BLANK_CYC  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .lz_suppress (lz_suppress),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .seg         (seg),
    .dig_n       (dig_n),
    .frame_done  (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_digit(input logic [1:0] a, input logic [3:0] d);
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL write_ready a=%0d: wr_ready=%b expected 1", a, wr_ready);
    end
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Advance to the next COMMIT cycle, optionally checking the display stays dark.
  task automatic run_to_commit(input bit dark);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        seen = 1'b1;
      end else if (dark) begin
        vectors++;
        if (seg !== BL) begin
          miscompares++;
          $display("FAIL dark_before_commit: seg=%b expected %b", seg, BL);
        end
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL commit_timeout: frame_done=%b expected 1 within 60 cycles", frame_done);
    end
  endtask

  // Check a whole frame starting at a COMMIT sample; digit d expects exp[d*7 +: 7].
  task automatic check_frame(input string name, input logic [27:0] exp, input int skip);
    for (int c = skip + 1; c <= 24; c++) begin
      int d = (c - 1) / 6;
      int p = (c - 1) % 6;
      logic [3:0] e_dig;
      logic [6:0] e_seg;
      tick();
      e_dig = (p < 2) ? DARK : dig_tab[d*4 +: 4];
      e_seg = (p < 2) ? BL : exp[d*7 +: 7];
      vectors++;
      if (dig_n !== e_dig || seg !== e_seg || frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s cyc%0d: dig_n=%b seg=%b fd=%b expected dig_n=%b seg=%b fd=0",
                 name, c, dig_n, seg, frame_done, e_dig, e_seg);
      end
    end
    tick();
    vectors++;
    if (frame_done !== 1'b1 || dig_n !== DARK || seg !== BL || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s commit: fd=%b dig_n=%b seg=%b wr_ready=%b expected fd=1 dig_n=1111 seg=%b wr_ready=0",
               name, frame_done, dig_n, seg, wr_ready, BL);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; lz_suppress = 1'b0;
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'd3;
    tick_n(2);
    vectors++;
    if (seg !== BL || dig_n !== DARK || wr_ready !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: seg=%b dig_n=%b wr_ready=%b fd=%b expected %b 1111 0 0",
               seg, dig_n, wr_ready, frame_done, BL);
    end
    rst = 1'b0; wr_valid = 1'b0;
    tick();
    vectors++;
    if (wr_ready !== 1'b1 || dig_n !== DARK) begin
      miscompares++;
      $display("FAIL reset_release: wr_ready=%b dig_n=%b expected 1 1111", wr_ready, dig_n);
    end
  endtask

  task automatic test_dark_frames();
    run_to_commit(1'b1);
    check_frame("dark_frame", {BL, BL, BL, BL}, 0);
  endtask

  task automatic test_write_commit();
    tick_n(3);
    write_digit(2'd0, 4'd1);
    write_digit(2'd1, 4'd2);
    write_digit(2'd2, 4'd3);
    write_digit(2'd3, 4'd4);
    run_to_commit(1'b1);
    check_frame("frame_1234", {P4, P3, P2, P1}, 0);
  endtask

  task automatic test_lz();
    lz_suppress = 1'b1;
    tick_n(3);
    write_digit(2'd3, 4'd0);
    write_digit(2'd2, 4'd0);
    write_digit(2'd1, 4'd0);
    write_digit(2'd0, 4'd7);
    run_to_commit(1'b0);
    check_frame("lz_on_0007", {BL, BL, BL, P7}, 0);
    lz_suppress = 1'b0;
    check_frame("lz_off_0007", {P0, P0, P0, P7}, 0);
    lz_suppress = 1'b1;
    tick_n(3);
    write_digit(2'd3, 4'd0);
    write_digit(2'd2, 4'd5);
    write_digit(2'd1, 4'd0);
    write_digit(2'd0, 4'd0);
    run_to_commit(1'b0);
    check_frame("lz_on_0500", {BL, P5, P0, P0}, 0);
    lz_suppress = 1'b0;
  endtask

  task automatic test_commit_stall();
    tick_n(24);
    vectors++;
    if (frame_done !== 1'b0 || wr_ready !== 1'b1 || dig_n !== 4'b0111) begin
      miscompares++;
      $display("FAIL last_show: fd=%b wr_ready=%b dig_n=%b expected 0 1 0111", frame_done, wr_ready, dig_n);
    end
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'd8;
    tick();
    vectors++;
    if (frame_done !== 1'b1 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_stall: fd=%b wr_ready=%b expected 1 0", frame_done, wr_ready);
    end
    wr_addr = 2'd2; wr_data = 4'd9;
    tick();
    vectors++;
    if (wr_ready !== 1'b1 || dig_n !== DARK) begin
      miscompares++;
      $display("FAIL post_commit_ready: wr_ready=%b dig_n=%b expected 1 1111", wr_ready, dig_n);
    end
    tick();
    wr_valid = 1'b0;
    check_frame("late_write_in", {P0, P5, P8, P0}, 2);
    check_frame("stalled_write", {P0, P9, P8, P0}, 0);
  endtask

  task automatic test_en_drop();
    tick_n(16);
    vectors++;
    if (dig_n !== 4'b1011 || seg !== P9) begin
      miscompares++;
      $display("FAIL show_digit2: dig_n=%b seg=%b expected 1011 %b", dig_n, seg, P9);
    end
    en = 1'b0;
    tick();
    vectors++;
    if (dig_n !== DARK || seg !== BL || frame_done !== 1'b0 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL en_drop: dig_n=%b seg=%b fd=%b wr_ready=%b expected 1111 %b 0 1",
               dig_n, seg, frame_done, wr_ready, BL);
    end
    write_digit(2'd0, 4'd5);
    tick_n(3);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (dig_n !== DARK || seg !== BL) begin
        miscompares++;
        $display("FAIL restart_blank%0d: dig_n=%b seg=%b expected 1111 %b", i, dig_n, seg, BL);
      end
    end
    tick();
    vectors++;
    if (dig_n !== 4'b1110 || seg !== P0) begin
      miscompares++;
      $display("FAIL restart_digit0: dig_n=%b seg=%b expected 1110 %b", dig_n, seg, P0);
    end
    run_to_commit(1'b0);
    check_frame("idle_write_commit", {P0, P9, P8, P5}, 0);
  endtask

  task automatic test_reset_mid();
    tick_n(3);
    write_digit(2'd1, 4'hC);
    run_to_commit(1'b0);
    tick_n(10);
    vectors++;
    if (dig_n !== 4'b1101 || seg !== BL) begin
      miscompares++;
      $display("FAIL digit1_code_c: dig_n=%b seg=%b expected 1101 %b", dig_n, seg, BL);
    end
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'd3;
    tick();
    vectors++;
    if (seg !== BL || dig_n !== DARK || wr_ready !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: seg=%b dig_n=%b wr_ready=%b fd=%b expected %b 1111 0 0",
               seg, dig_n, wr_ready, frame_done, BL);
    end
    rst = 1'b0; wr_valid = 1'b0;
    tick();
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_release: wr_ready=%b expected 1", wr_ready);
    end
    run_to_commit(1'b1);
    check_frame("banks_cleared", {BL, BL, BL, BL}, 0);
  endtask

  initial begin
    test_reset();
    test_dark_frames();
    test_write_commit();
    test_lz();
    test_commit_stall();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 time units, expected to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
